// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter that shares one FIFO write port among NREQ requesters.
// An IDLE arbitration cycle precedes every burst, and a burst is capped at MAX_BURST words.
module fifo_wr_arbiter #(
    parameter int DATESIZE  = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4,
    localparam int IDW      = $clog2(NREQ),
    localparam int BCW      = $clog2(MAX_BURST) + 1
) (
    input  logic                     wclk,
    input  logic                     w_rstn,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATESIZE-1:0] req_data,
    output logic [NREQ-1:0]          ack,
    input  logic                     wfull,
    output logic                     winc,
    output logic [DATESIZE-1:0]      wdata,
    output logic                     gnt_valid,
    output logic [IDW-1:0]           gnt_id
);

    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_BURST = 1'b1;

    localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);

    logic                state_reg,    state_next;
    logic [IDW-1:0]      rr_ptr_reg,   rr_ptr_next;
    logic [IDW-1:0]      gnt_id_reg,   gnt_id_next;
    logic [BCW-1:0]      beat_cnt_reg, beat_cnt_next;

    logic [NREQ-1:0]     owner_sel;
    logic                owner_req;
    logic                last_beat;
    logic [IDW-1:0]      winner;
    logic [IDW-1:0]      gnt_id_inc;
    logic [DATESIZE-1:0] masked_data [NREQ];

    // Only the owner's request matters while a burst is running.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
            assign owner_sel[gi]   = (gnt_id_reg == IDW'(gi));
            assign ack[gi]         = (state_reg == STATE_BURST) && owner_sel[gi] &&
                                     req[gi] && !wfull;
            assign masked_data[gi] = ack[gi] ? req_data[gi*DATESIZE +: DATESIZE] : '0;
        end
    endgenerate

    assign owner_req = |(req & owner_sel);
    assign winc      = |ack;
    assign last_beat = (beat_cnt_reg == LAST_BEAT);
    assign gnt_valid = (state_reg == STATE_BURST);
    assign gnt_id    = gnt_id_reg;

    // ack is one-hot, so OR-ing the masked lanes forms the data mux.
    always_comb begin
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            wdata = wdata | masked_data[i];
        end
    end

    // Wrap explicitly so a non-power-of-two NREQ never yields an unused index.
    assign gnt_id_inc = (gnt_id_reg == LAST_ID) ? '0 : gnt_id_reg + 1'b1;

    // Scan requesters starting at rr_ptr and take the first one that is asserted.
    always_comb begin
        logic [IDW-1:0] idx;
        logic           found;
        winner = rr_ptr_reg;
        found  = 1'b0;
        idx    = rr_ptr_reg;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
            idx = (idx == LAST_ID) ? '0 : idx + 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        gnt_id_next   = gnt_id_reg;
        beat_cnt_next = beat_cnt_reg;
        if (state_reg == STATE_IDLE) begin
            if (|req) begin
                gnt_id_next   = winner;
                beat_cnt_next = '0;
                state_next    = STATE_BURST;
            end
        end else begin
            // A dropped request ends the burst even if wfull is also high.
            if (!owner_req) begin
                state_next  = STATE_IDLE;
                rr_ptr_next = gnt_id_inc;
            end else if (winc) begin
                beat_cnt_next = beat_cnt_reg + 1'b1;
                if (last_beat) begin
                    state_next  = STATE_IDLE;
                    rr_ptr_next = gnt_id_inc;
                end
            end
        end
    end

    always_ff @(posedge wclk or negedge w_rstn) begin
        if (!w_rstn) begin
            state_reg    <= STATE_IDLE;
            rr_ptr_reg   <= '0;
            gnt_id_reg   <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            gnt_id_reg   <= gnt_id_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed bursts, stalls, early drops, mid-burst reset,
// and an end-to-end run into a small FIFO model that is drained slowly.
module tb_fifo_wr_arbiter;

    localparam int DATESIZE  = 8;
    localparam int NREQ      = 4;
    localparam int MAX_BURST = 4;
    localparam int IDW       = 2;
    localparam int FIFO_DEPTH = 8;

    logic                     wclk = 1'b0;
    logic                     w_rstn;
    logic [NREQ-1:0]          req;
    logic [NREQ*DATESIZE-1:0] req_data;
    logic [NREQ-1:0]          ack;
    logic                     wfull;
    logic                     winc;
    logic [DATESIZE-1:0]      wdata;
    logic                     gnt_valid;
    logic [IDW-1:0]           gnt_id;

    fifo_wr_arbiter #(
        .DATESIZE  (DATESIZE),
        .NREQ      (NREQ),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .wclk      (wclk),
        .w_rstn    (w_rstn),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        int id;
        int data;
        int cyc;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] src_q [NREQ][$];
    logic [7:0] e2e_exp [NREQ][$];
    logic [7:0] fifo_q [$];

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         stall_lo = 1000;
    int         stall_hi = -1;
    bit         e2e      = 1'b0;
    logic [NREQ-1:0] last_ack  = '0;
    logic            last_winc = 1'b0;
    logic [7:0]      last_wdata = '0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [7:0] mk(input int id, input int seq);
        return 8'((id << 6) | seq);
    endfunction

    task automatic push_exp(input int id, input int data, input int c);
        exp_t e;
        e.id = id; e.data = data; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Sampled on the falling edge, half a cycle away from the DUT's active edge.
    task automatic sample();
        exp_t e;
        if (wfull) check("winc_while_full", winc, 0);
        if (winc) begin
            $display("wr cyc=%0d id=%0d data=%02h", cyc, gnt_id, wdata);
            check("wr_gnt_valid", gnt_valid, 1);
            if (e2e) begin
                check("e2e_id", gnt_id, wdata[7:6]);
                check("e2e_ack", ack, 4'b0001 << wdata[7:6]);
            end else if (exp_q.size() == 0) begin
                check("spurious_write", winc, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_id", gnt_id, e.id);
                check("wr_data", wdata, e.data);
                check("wr_ack", ack, 4'b0001 << e.id);
                if (e.cyc >= 0) check("wr_cycle", cyc, e.cyc);
            end
        end else begin
            check("ack_without_winc", ack, 0);
            check("wdata_idle", wdata, 0);
        end
        last_ack   = ack;
        last_winc  = winc;
        last_wdata = wdata;
    endtask

    // Requester and FIFO models advance just after the active edge.
    task automatic update_inputs();
        logic [7:0] w;
        logic [7:0] e;
        int id;
        for (int i = 0; i < NREQ; i++) begin
            if (last_ack[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        if (e2e) begin
            if (last_winc) fifo_q.push_back(last_wdata);
            if ((cyc % 4) == 0 && fifo_q.size() > 0) begin
                w  = fifo_q.pop_front();
                id = int'(w[7:6]);
                if (e2e_exp[id].size() == 0) begin
                    check("e2e_extra_word", e2e_exp[id].size(), 1);
                end else begin
                    e = e2e_exp[id].pop_front();
                    check("e2e_order", w, e);
                end
            end
            wfull = (fifo_q.size() >= FIFO_DEPTH);
        end else begin
            wfull = (cyc >= stall_lo) && (cyc <= stall_hi);
        end
        last_ack  = '0;
        last_winc = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req[i] = (src_q[i].size() > 0);
            req_data[i*DATESIZE +: DATESIZE] = req[i] ? src_q[i][0] : 8'h00;
        end
    endtask

    task automatic step();
        @(negedge wclk);
        sample();
        @(posedge wclk);
        #1;
        cyc++;
        update_inputs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic start_test();
        cyc = 0;
        update_inputs();
    endtask

    task automatic do_reset();
        w_rstn = 1'b0;
        #2;
        w_rstn = 1'b1;
        last_ack  = '0;
        last_winc = 1'b0;
    endtask

    task automatic sb_done(input string tag);
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int b;
        int budget;
        int left;
        w_rstn   = 1'b0;
        req      = 4'b1111;
        req_data = 32'hA5A5_A5A5;
        wfull    = 1'b0;
        repeat (2) @(posedge wclk);
        #1;
        check("rst_ack", ack, 0);
        check("rst_winc", winc, 0);
        check("rst_wdata", wdata, 0);
        check("rst_gnt_valid", gnt_valid, 0);
        check("rst_gnt_id", gnt_id, 0);
        w_rstn = 1'b1;

        // T1: one requester, two back-to-back bursts with an idle cycle between.
        for (int k = 0; k < 8; k++) begin
            src_q[1].push_back(8'h10 + 8'(k));
            push_exp(1, 'h10 + k, (k < 4) ? (k + 1) : (k + 2));
        end
        start_test();
        check("t1_idle_gnt_valid", gnt_valid, 0);
        run(12);
        sb_done("t1_all_written");

        // T2: all four requesting; owners rotate 0,1,2,3,0,...; 5 cycles per burst.
        do_reset();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 8; k++) src_q[i].push_back(mk(i, k));
        for (b = 0; b < 8; b++)
            for (int j = 0; j < MAX_BURST; j++)
                push_exp(b % NREQ, mk(b % NREQ, 4 * (b / NREQ) + j), 5 * b + 1 + j);
        start_test();
        run(42);
        sb_done("t2_all_written");

        // T3: wfull for 3 cycles after beat 2; beat count must be held through the stall.
        do_reset();
        for (int k = 0; k < 6; k++) src_q[0].push_back(mk(0, k));
        push_exp(0, mk(0, 0), 1);
        push_exp(0, mk(0, 1), 2);
        push_exp(0, mk(0, 2), 6);
        push_exp(0, mk(0, 3), 7);
        push_exp(0, mk(0, 4), 9);
        push_exp(0, mk(0, 5), 10);
        stall_lo = 3;
        stall_hi = 5;
        start_test();
        run(13);
        sb_done("t3_all_written");
        stall_lo = 1000;
        stall_hi = -1;

        // T4: requester 1 burst sets rr_ptr=2; then 2 drops after 2 beats, so 3 precedes 0.
        for (int k = 0; k < 4; k++) begin
            src_q[1].push_back(mk(1, k));
            push_exp(1, mk(1, k), k + 1);
        end
        start_test();
        run(6);
        sb_done("t4a_all_written");
        for (int k = 0; k < 2; k++) begin
            src_q[2].push_back(mk(2, k));
            src_q[3].push_back(mk(3, k));
            src_q[0].push_back(mk(0, k));
        end
        push_exp(2, mk(2, 0), 1);
        push_exp(2, mk(2, 1), 2);
        push_exp(3, mk(3, 0), 5);
        push_exp(3, mk(3, 1), 6);
        push_exp(0, mk(0, 0), 9);
        push_exp(0, mk(0, 1), 10);
        start_test();
        run(13);
        sb_done("t4b_all_written");

        // T5: rr_ptr=1 so requester 1 owns; reset at beat 1, then requester 0 wins.
        for (int k = 0; k < 4; k++) begin
            src_q[0].push_back(mk(0, k));
            src_q[1].push_back(mk(1, k));
        end
        push_exp(1, mk(1, 0), 1);
        start_test();
        run(2);
        sb_done("t5_first_beat");
        check("t5_pre_rst_winc", winc, 1);
        #1;
        w_rstn = 1'b0;
        #1;
        check("t5_rst_winc", winc, 0);
        check("t5_rst_ack", ack, 0);
        check("t5_rst_gnt_valid", gnt_valid, 0);
        check("t5_rst_gnt_id", gnt_id, 0);
        @(posedge wclk);
        #1;
        w_rstn    = 1'b1;
        last_ack  = '0;
        last_winc = 1'b0;
        for (int k = 0; k < 4; k++) push_exp(0, mk(0, k), k + 1);
        for (int k = 1; k < 4; k++) push_exp(1, mk(1, k), k + 5);
        start_test();
        run(11);
        sb_done("t5_all_written");

        // T6: three requesters into an 8-deep FIFO model drained every 4th cycle.
        do_reset();
        e2e = 1'b1;
        fifo_q.delete();
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 8; k++) begin
                src_q[i].push_back(mk(i, k));
                e2e_exp[i].push_back(mk(i, k));
            end
        start_test();
        budget = 0;
        while (budget < 3000) begin
            step();
            budget++;
            if (src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
                fifo_q.size() == 0 && !winc)
                break;
        end
        check("t6_within_budget", budget < 3000, 1);
        left = e2e_exp[0].size() + e2e_exp[1].size() + e2e_exp[2].size();
        check("t6_words_missing", left, 0);
        check("t6_fifo_empty", fifo_q.size(), 0);
        e2e = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
